// File: rtl/spi_master_ctrl_if.sv
// System-side command/status and SPI pin bundle for spi_master_ctrl.
// master: the controller itself; slave: whatever drives commands and models the pins.
interface spi_master_ctrl_if #(
    parameter int WIDTH = 13
);
    logic             start;
    logic             clr_req;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             done;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_load;
    logic             spi_clr;
    logic             spi_miso;

    modport master (
        input  start, clr_req, tx_data, spi_miso,
        output rx_data, busy, done, spi_sclk, spi_mosi, spi_load, spi_clr
    );

    modport slave (
        output start, clr_req, tx_data, spi_miso,
        input  rx_data, busy, done, spi_sclk, spi_mosi, spi_load, spi_clr
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencing a load/shift slave: preload, WIDTH-bit MSB-first shift, commit.
// Latency: done (2*WIDTH+3)*HALF_DIV cycles after the accepted start; all outputs registered.
// No backpressure: start/clr_req are sampled only when idle (start also in DONE), else ignored.
module spi_master_ctrl #(
    parameter int WIDTH    = 13,
    parameter int HALF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.master bus
);
    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, LATCH_GAP, LATCH, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             phase, phase_nxt;     // 0: sclk low phase, 1: sclk high phase
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic             cap, sample, adv, div_last;
    logic [WIDTH-1:0] tx_sh, rx_sh;

    assign div_last = (cnt == CW'(HALF_DIV - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = div_last ? '0 : cnt + 1'b1;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        cap       = 1'b0;
        sample    = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                phase_nxt = 1'b0;
                bit_nxt   = '0;
                if (bus.clr_req) begin
                    state_nxt = CLR;
                end else if (bus.start) begin
                    state_nxt = LOAD;
                    cap       = 1'b1;
                end
            end
            CLR:  if (div_last) state_nxt = IDLE;
            LOAD: if (div_last) state_nxt = SHIFT;
            SHIFT: begin
                if (div_last) begin
                    if (!phase) begin
                        phase_nxt = 1'b1;
                        sample    = 1'b1;
                    end else if (bit_cnt == BW'(WIDTH - 1)) begin
                        phase_nxt = 1'b0;
                        state_nxt = LATCH_GAP;
                    end else begin
                        phase_nxt = 1'b0;
                        bit_nxt   = bit_cnt + 1'b1;
                        adv       = 1'b1;
                    end
                end
            end
            LATCH_GAP: if (div_last) state_nxt = LATCH;
            LATCH:     if (div_last) state_nxt = DONE;
            DONE: begin
                // a held start chains straight into the next frame
                cnt_nxt   = '0;
                phase_nxt = 1'b0;
                bit_nxt   = '0;
                if (bus.start) begin
                    state_nxt = LOAD;
                    cap       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            phase        <= 1'b0;
            bit_cnt      <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            bus.rx_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.spi_sclk <= 1'b0;
            bus.spi_mosi <= 1'b0;
            bus.spi_load <= 1'b0;
            bus.spi_clr  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            phase        <= phase_nxt;
            bit_cnt      <= bit_nxt;
            bus.busy     <= (state_nxt != IDLE);
            bus.done     <= (state_nxt == DONE);
            bus.spi_sclk <= (state_nxt == SHIFT) && phase_nxt;
            bus.spi_load <= (state_nxt == LOAD) || (state_nxt == LATCH);
            bus.spi_clr  <= (state_nxt == CLR);
            if (cap) begin
                tx_sh        <= bus.tx_data;
                bus.spi_mosi <= bus.tx_data[WIDTH-1];
            end else if (adv) begin
                tx_sh        <= tx_sh << 1;
                bus.spi_mosi <= tx_sh[WIDTH-2];
            end else if (state_nxt == DONE) begin
                bus.spi_mosi <= 1'b0;
            end
            if (sample) rx_sh <= {rx_sh[WIDTH-2:0], bus.spi_miso};
            if (state_nxt == DONE) bus.rx_data <= rx_sh;
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with behavioural load/shift slaves on two DUTs
// (HALF_DIV=2 and HALF_DIV=1).
module tb_spi_master_ctrl;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_ctrl_if #(.WIDTH(W)) ia ();
    spi_master_ctrl_if #(.WIDTH(W)) ib ();

    spi_master_ctrl #(.WIDTH(W), .HALF_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    spi_master_ctrl #(.WIDTH(W), .HALF_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    // Slave models: load commits rx and preloads din; sample on sclk rise, shift on fall.
    logic [W-1:0] s_tx_a = '0, s_rx_a = '0, s_dout_a = '0, s_din_a = '0;
    logic [W-1:0] s_tx_b = '0, s_rx_b = '0, s_dout_b = '0, s_din_b = '0;

    always @(posedge ia.spi_load) begin s_dout_a = s_rx_a; s_tx_a = s_din_a; end
    always @(posedge ia.spi_sclk) s_rx_a = {s_rx_a[W-2:0], ia.spi_mosi};
    always @(negedge ia.spi_sclk) s_tx_a = s_tx_a << 1;
    always @(posedge ia.spi_clr)  s_dout_a = '0;
    assign ia.spi_miso = s_tx_a[W-1];

    always @(posedge ib.spi_load) begin s_dout_b = s_rx_b; s_tx_b = s_din_b; end
    always @(posedge ib.spi_sclk) s_rx_b = {s_rx_b[W-2:0], ib.spi_mosi};
    always @(negedge ib.spi_sclk) s_tx_b = s_tx_b << 1;
    always @(posedge ib.spi_clr)  s_dout_b = '0;
    assign ib.spi_miso = s_tx_b[W-1];

    typedef struct {
        logic [W-1:0] rx;
        logic [W-1:0] slv;
        int           cyc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitors: compare each done pulse against the oldest expected frame.
    int   rises_a = 0, rises_b = 0, clr_cyc_a = 0, load_rises_a = 0, done_cnt_a = 0;
    logic sclk_prev_a = 1'b0, load_prev_a = 1'b0, sclk_prev_b = 1'b0;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            rises_a = 0;
        end else begin
            if (ia.spi_sclk && !sclk_prev_a) rises_a++;
            if (ia.spi_load && !load_prev_a) load_rises_a++;
            if (ia.spi_clr) clr_cyc_a++;
            if (ia.done) begin
                done_cnt_a++;
                if (qa.size() == 0) begin
                    chk("done_a_unexpected", ia.done, 1'b0);
                end else begin
                    ea = qa.pop_front();
                    chk("rx_a", ia.rx_data, ea.rx);
                    chk("slave_out_a", s_dout_a, ea.slv);
                    chk("done_cycle_a", cyc, ea.cyc);
                    chk("sclk_rises_a", rises_a, W);
                end
                rises_a = 0;
            end
        end
        sclk_prev_a = ia.spi_sclk;
        load_prev_a = ia.spi_load;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rises_b = 0;
        end else begin
            if (ib.spi_sclk && !sclk_prev_b) rises_b++;
            if (ib.done) begin
                if (qb.size() == 0) begin
                    chk("done_b_unexpected", ib.done, 1'b0);
                end else begin
                    eb = qb.pop_front();
                    chk("rx_b", ib.rx_data, eb.rx);
                    chk("slave_out_b", s_dout_b, eb.slv);
                    chk("done_cycle_b", cyc, eb.cyc);
                    chk("sclk_rises_b", rises_b, W);
                end
                rises_b = 0;
            end
        end
        sclk_prev_b = ib.spi_sclk;
    end

    task automatic launch(input bit b, input logic [W-1:0] tx, output int acc);
        @(posedge clk); #1;
        if (b) begin ib.start = 1'b1; ib.tx_data = tx; end
        else   begin ia.start = 1'b1; ia.tx_data = tx; end
        acc = cyc + 1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic wait_sb(input bit b, input int budget);
        int n = 0;
        while ((b ? qb.size() : qa.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(b ? "timeout_b" : "timeout_a", b ? qb.size() : qa.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int acc, busy_n, d0, c0, l0;

    initial begin
        rst_n = 1'b0;
        ia.start = 1'b0; ia.clr_req = 1'b0; ia.tx_data = '0;
        ib.start = 1'b0; ib.clr_req = 1'b0; ib.tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ia.busy, 1'b0);
        chk("rst_done", ia.done, 1'b0);
        chk("rst_sclk", ia.spi_sclk, 1'b0);
        chk("rst_mosi", ia.spi_mosi, 1'b0);
        chk("rst_load", ia.spi_load, 1'b0);
        chk("rst_clr",  ia.spi_clr, 1'b0);
        chk("rst_rx",   ia.rx_data, '0);
        rst_n = 1'b1;

        // Single frame with busy window
        s_din_a = 13'h0ABC;
        launch(1'b0, 13'h1555, acc);
        qa.push_back('{rx: 13'h0ABC, slv: 13'h1555, cyc: acc + 58});
        busy_n = int'(ia.busy);
        for (int i = 0; i < 61; i++) begin
            @(posedge clk); #1;
            busy_n += int'(ia.busy);
        end
        chk("busy_cycles", busy_n, 59);
        wait_sb(1'b0, 100);

        // Reset in the middle of bit 5
        s_din_a = 13'h0333;
        launch(1'b0, 13'h0AAA, acc);
        repeat (24) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", ia.busy, 1'b0);
        chk("abort_sclk", ia.spi_sclk, 1'b0);
        chk("abort_mosi", ia.spi_mosi, 1'b0);
        chk("abort_load", ia.spi_load, 1'b0);
        chk("abort_rx",   ia.rx_data, '0);
        chk("abort_slave_out", s_dout_a, 13'h1555);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_busy", ia.busy, 1'b0);

        // Back-to-back with start held
        s_din_a = 13'h1234;
        @(posedge clk); #1;
        ia.start = 1'b1; ia.tx_data = 13'h1FFF;
        acc = cyc + 1;
        qa.push_back('{rx: 13'h1234, slv: 13'h1FFF, cyc: acc + 58});
        qa.push_back('{rx: 13'h1234, slv: 13'h0001, cyc: acc + 117});
        @(posedge clk); #1 ia.tx_data = 13'h0001;
        repeat (58) @(posedge clk);
        #1 chk("b2b_done_first", ia.done, 1'b1);
        @(posedge clk); #1;
        chk("b2b_load_after_done", ia.spi_load, 1'b1);
        ia.start = 1'b0;
        wait_sb(1'b0, 200);

        // Starts during a frame are ignored
        s_din_a = 13'h0777;
        d0 = done_cnt_a;
        launch(1'b0, 13'h0B6D, acc);
        qa.push_back('{rx: 13'h0777, slv: 13'h0B6D, cyc: acc + 58});
        repeat (9) @(posedge clk);
        #1 begin ia.start = 1'b1; ia.tx_data = 13'h1FFF; end
        @(posedge clk); #1 ia.start = 1'b0;
        repeat (29) @(posedge clk);
        #1 begin ia.start = 1'b1; ia.tx_data = 13'h0000; end
        @(posedge clk); #1 ia.start = 1'b0;
        wait_sb(1'b0, 100);
        repeat (70) @(posedge clk);
        chk("ignored_starts_done_count", done_cnt_a - d0, 1);

        // clr_req beats a simultaneous start
        d0 = done_cnt_a; c0 = clr_cyc_a; l0 = load_rises_a;
        @(posedge clk); #1;
        ia.clr_req = 1'b1; ia.start = 1'b1; ia.tx_data = 13'h1555;
        @(posedge clk); #1;
        ia.clr_req = 1'b0; ia.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("clr_cycles", clr_cyc_a - c0, 2);
        chk("clr_no_load", load_rises_a - l0, 0);
        chk("clr_no_done", done_cnt_a - d0, 0);
        chk("clr_slave_out", s_dout_a, '0);
        chk("clr_busy", ia.busy, 1'b0);

        // HALF_DIV = 1
        s_din_b = 13'h1ACE;
        launch(1'b1, 13'h0F0F, acc);
        qb.push_back('{rx: 13'h1ACE, slv: 13'h0F0F, cyc: acc + 29});
        wait_sb(1'b1, 60);
        repeat (3) @(posedge clk);
        #1 chk("b_idle_busy", ib.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
